// File: rtl/fp16_pkg.sv
// Shared fp16 field layout, classification and int8 limits for the requantiser stream stages.
package fp16_pkg;
  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 10;
  localparam int FP16_W   = SIGN_W + EXP_W + MANT_W;
  localparam int EXP_BIAS = 15;
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   mant;
    fp_class_t         cls;
  } fp_dec_t;

  // Subnormals are folded into FP_ZERO: they can never round to a nonzero int8.
  function automatic fp_dec_t fp_decode(input logic [FP16_W-1:0] v);
    fp_dec_t          d;
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    e      = v[FP16_W-2 -: EXP_W];
    m      = v[MANT_W-1:0];
    d.sign = v[FP16_W-1];
    d.exp  = e;
    d.mant = {e != '0, m};
    if (e == '0)      d.cls = FP_ZERO;
    else if (e == '1) d.cls = (m == '0) ? FP_INF : FP_NAN;
    else              d.cls = FP_NORM;
    return d;
  endfunction
endpackage

// File: rtl/fp16_to_int8_requant_if.sv
// Stream bundle between the fp16 accumulator source, the requantiser and the int8 consumer.
interface fp16_to_int8_requant_if;
  import fp16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [FP16_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_data;
  logic [15:0]       sat_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sat_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sat_count
  );
endinterface

// File: rtl/sync_fifo.sv
// Generic FIFO with a registered head; a push into an empty FIFO is visible the next cycle.
// Overflow is the writer's problem: gate pushes on count (push+pop when full is legal).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic             pop;

  assign rd_vld = (count != '0);
  assign pop    = rd_vld && rd_rdy;
  assign rd_nxt = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rd_dat <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_nxt;
      unique case ({wr_vld, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // Head register follows the next entry; it keeps the last popped value once empty.
      if (pop) begin
        if (count > CNT_W'(1)) rd_dat <= mem[rd_nxt];
        else if (wr_vld)       rd_dat <= wr_dat;
      end else if (count == '0 && wr_vld) begin
        rd_dat <= wr_dat;
      end
    end
  end
endmodule

// File: rtl/fp16_to_int8_requant.sv
// fp16 accumulator stream -> decimated, rounded, saturated int8; 2 edges to out_valid on an empty FIFO.
// in_ready is a credit check over FIFO entries plus kept samples in flight, so nothing is ever dropped.
module fp16_to_int8_requant
  import fp16_pkg::*;
#(
  parameter int KEEP_EVERY = 2,
  parameter int RELU       = 0,
  parameter int DEPTH      = 4
) (
  input logic                   clk,
  input logic                   rst,
  fp16_to_int8_requant_if.slave bus
);
  localparam int PH_W  = (KEEP_EVERY > 1) ? $clog2(KEEP_EVERY) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PH_W-1:0]   phase;
  logic              accept;
  logic              keep;
  logic              s0_vld;
  logic [FP16_W-1:0] s0_dat;
  logic              s1_vld;
  fp_dec_t           s1;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [15:0]       sat_cnt;
  logic [7:0]        res;
  logic              sat;
  logic [3:0]        sh;
  logic [MANT_W:0]   shifted;
  logic [7:0]        mag;
  logic              big;

  assign accept       = bus.in_valid && bus.in_ready;
  assign keep         = (phase == PH_W'(KEEP_EVERY - 1));
  assign bus.in_ready = !rst && ((int'(fifo_cnt) + int'(s0_vld) + int'(s1_vld)) < DEPTH);
  assign bus.sat_count = sat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= '0;
      s0_vld  <= 1'b0;
      s1_vld  <= 1'b0;
      sat_cnt <= '0;
    end else begin
      s0_vld <= accept && keep;
      s1_vld <= s0_vld;
      if (accept) phase <= keep ? '0 : phase + PH_W'(1);
      if (s1_vld && sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) s0_dat <= bus.in_data;
    if (s0_vld) s1     <= fp_decode(s0_dat);
  end

  always_comb begin
    mag     = '0;
    big     = 1'b0;
    shifted = '0;
    res     = '0;
    sat     = 1'b0;
    sh      = 4'(EXP_BIAS + MANT_W - int'(s1.exp));
    unique case (s1.cls)
      FP_INF:  big = 1'b1;
      FP_NORM: begin
        if (s1.exp > EXP_W'(EXP_BIAS + 6)) begin
          big = 1'b1;
        end else if (s1.exp >= EXP_W'(EXP_BIAS)) begin
          // Keep one extra bit below the integer point as the round-half-away guard.
          shifted = s1.mant >> (sh - 4'd1);
          mag     = 8'(shifted[MANT_W:1]) + 8'(shifted[0]);
        end else if (s1.exp == EXP_W'(EXP_BIAS - 1)) begin
          mag = 8'd1;
        end
      end
      default: ;
    endcase
    if (big) begin
      res = s1.sign ? 8'(INT8_MIN) : 8'(INT8_MAX);
      sat = !(s1.sign && s1.cls == FP_NORM && s1.exp == EXP_W'(EXP_BIAS + 7) &&
              s1.mant == {1'b1, {MANT_W{1'b0}}});
    end else if (s1.sign) begin
      res = -mag;
    end else if (mag > 8'(INT8_MAX)) begin
      res = 8'(INT8_MAX);
      sat = 1'b1;
    end else begin
      res = mag;
    end
    if (RELU != 0 && s1.sign) begin
      res = '0;
      sat = 1'b0;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (s1_vld),
    .wr_dat (res),
    .rd_vld (bus.out_valid),
    .rd_rdy (bus.out_ready),
    .rd_dat (bus.out_data),
    .count  (fifo_cnt)
  );
endmodule

// File: tb/tb_fp16_to_int8_requant.sv
// Three requantiser configurations share one stimulus stream; each has its own scoreboard and real-valued model.
module tb_fp16_to_int8_requant;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic real pow2(input int n);
    real p = 1.0;
    for (int i = 0; i < ((n < 0) ? -n : n); i++) p = (n < 0) ? p / 2.0 : p * 2.0;
    return p;
  endfunction

  // Value-level reference: decode to a real, round half away from zero, clamp to int8.
  function automatic void ref_conv(input logic [15:0] x, input int relu,
                                   output logic [7:0] y, output bit s);
    int  e, m, r;
    real v;
    e = int'(x[14:10]);
    m = int'(x[9:0]);
    y = 8'h00;
    s = 1'b0;
    if (e == 31 && m != 0) return;
    if (relu != 0 && x[15]) return;
    if (e == 31)     v = 1.0e6;
    else if (e == 0) v = m * pow2(-24);
    else             v = (1024 + m) * pow2(e - 25);
    if (x[15]) v = -v;
    r = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
    if (r > 127) begin
      y = 8'h7F;
      s = 1'b1;
    end else if (v < -128.0) begin
      y = 8'h80;
      s = 1'b1;
    end else begin
      y = 8'(r);
    end
  endfunction

  function automatic logic [15:0] rnd_fp16();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return {1'($urandom), 5'($urandom_range(12, 23)), 10'($urandom)};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int K = (g == 2) ? 2 : 1;
    localparam int R = (g == 1) ? 1 : 0;

    fp16_to_int8_requant_if bus ();

    fp16_to_int8_requant #(.KEEP_EVERY(K), .RELU(R), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.out_ready = out_ready;

    logic [7:0] expq[$];
    int         acc_cnt = 0;
    int         exp_sat = 0;
    int         n_out = 0;

    // Inputs change just after posedge, so the negedge view is what the next edge will act on.
    always @(negedge clk) begin
      logic [7:0] y;
      bit         s;
      if (rst) begin
        expq.delete();
        acc_cnt = 0;
        exp_sat = 0;
        n_out   = 0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_unexpected[%0d]: got 0x%0h, expected no output", g, bus.out_data);
          end else begin
            check($sformatf("out_data[%0d]", g), 32'(bus.out_data), 32'(expq.pop_front()));
          end
          n_out++;
        end
        if (bus.in_valid && bus.in_ready) begin
          if (acc_cnt % K == K - 1) begin
            ref_conv(bus.in_data, R, y, s);
            expq.push_back(y);
            if (s && exp_sat < 65535) exp_sat++;
          end
          acc_cnt++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x);
    in_valid = 1'b1;
    in_data  = x;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic ov, input logic [7:0] od, input logic [15:0] sc);
    check({tag, "_out_valid"}, 32'(ov), 32'd0);
    check({tag, "_out_data"}, 32'(od), 32'd0);
    check({tag, "_sat_count"}, 32'(sc), 32'd0);
  endtask

  logic [15:0] list_a [8] = '{16'hD640, 16'h4100, 16'hC100, 16'h3800,
                              16'h5A00, 16'hFC00, 16'hD800, 16'h7E00};
  logic [15:0] list_b [9] = '{16'h3400, 16'h3E00, 16'hBE00, 16'h0001, 16'h57F0,
                              16'h7C00, 16'hD801, 16'hD7F8, 16'h8000};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    check_idle("rst0", gi[0].bus.out_valid, gi[0].bus.out_data, gi[0].bus.sat_count);
    check_idle("rst1", gi[1].bus.out_valid, gi[1].bus.out_data, gi[1].bus.sat_count);
    check_idle("rst2", gi[2].bus.out_valid, gi[2].bus.out_data, gi[2].bus.sat_count);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(gi[0].bus.in_ready), 32'd1);

    // Two-edge latency on an empty FIFO
    tick(1);
    send(16'h5640);
    @(negedge clk);
    check("lat_edge_n", 32'(gi[0].bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge_n1", 32'(gi[0].bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge_n2", 32'(gi[0].bus.out_valid), 32'd1);
    check("lat_data", 32'(gi[0].bus.out_data), 32'h64);
    tick(1);

    // Rounding and saturation set
    foreach (list_a[i]) send(list_a[i]);
    tick(8);
    check("sat_cnt_plain", 32'(gi[0].bus.sat_count), 32'd2);
    check("sat_cnt_relu", 32'(gi[1].bus.sat_count), 32'd1);
    foreach (list_b[i]) send(list_b[i]);
    tick(8);
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: check("sat_cnt_b0", 32'(gi[0].bus.sat_count), 32'(gi[0].exp_sat));
        1: check("sat_cnt_b1", 32'(gi[1].bus.sat_count), 32'(gi[1].exp_sat));
        default: check("sat_cnt_b2", 32'(gi[2].bus.sat_count), 32'(gi[2].exp_sat));
      endcase
    end

    // Decimation by two, then reset between groups
    do_reset();
    send(16'h3C00); send(16'h4000); send(16'h4200); send(16'h4400);
    tick(8);
    check("keep2_count", 32'(gi[2].n_out), 32'd2);
    check("keep2_last_held", 32'(gi[2].bus.out_data), 32'h04);
    do_reset();
    send(16'h3C00); send(16'h4000); send(16'h4200);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send(16'h4500); send(16'h4600);
    tick(8);
    check("keep2_after_rst_count", 32'(gi[2].n_out), 32'd1);
    check("keep2_after_rst_data", 32'(gi[2].bus.out_data), 32'h06);

    // Backpressure: credits cover in-flight entries
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = rnd_fp16();
      tick(1);
    end
    @(negedge clk);
    check("bp_in_ready_low", 32'(gi[0].bus.in_ready), 32'd0);
    check("bp_accepted_k1", 32'(gi[0].acc_cnt), 32'd4);
    check("bp_accepted_k2", 32'(gi[2].acc_cnt), 32'd8);
    check("bp_out_valid", 32'(gi[0].bus.out_valid), 32'd1);
    tick(1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(8);
    check("bp_popped_k1", 32'(gi[0].n_out), 32'd4);
    check("bp_popped_k2", 32'(gi[2].n_out), 32'd4);
    check("bp_in_ready_back", 32'(gi[0].bus.in_ready), 32'd1);
    check("bp_queue_empty", 32'(gi[0].expq.size()), 32'd0);

    // Reset with three entries buffered
    do_reset();
    out_ready = 1'b0;
    send(16'h5A00); send(16'h4100); send(16'h3C00);
    tick(4);
    check("mid_sat_before", 32'(gi[0].bus.sat_count), 32'd1);
    check("mid_out_valid_before", 32'(gi[0].bus.out_valid), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_idle("mid_rst", gi[0].bus.out_valid, gi[0].bus.out_data, gi[0].bus.sat_count);
    tick(6);
    check("mid_no_stale", 32'(gi[0].n_out), 32'd0);

    // Randomised traffic with one reset in the middle
    for (int i = 0; i < 1500; i++) begin
      rst       = (i == 700);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = rnd_fp16();
      out_ready = ($urandom_range(0, 9) < 6);
      tick(1);
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(12);
    check("rnd_drain0", 32'(gi[0].expq.size()), 32'd0);
    check("rnd_drain1", 32'(gi[1].expq.size()), 32'd0);
    check("rnd_drain2", 32'(gi[2].expq.size()), 32'd0);
    check("rnd_sat0", 32'(gi[0].bus.sat_count), 32'(gi[0].exp_sat));
    check("rnd_sat1", 32'(gi[1].bus.sat_count), 32'(gi[1].exp_sat));
    check("rnd_sat2", 32'(gi[2].bus.sat_count), 32'(gi[2].exp_sat));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fp16_to_int8_requant.md
Name: fp16_to_int8_requant

Overview:
- Output-side counterpart of the int8->fp16 input converter: takes the fp16 accumulator stream from the MAC/adder datapath and returns signed int8 activations for the next layer.
- Decimates the stream so only the final sum of each block is kept, rounds and saturates to int8, and optionally applies ReLU.
- Buffers results in a small FIFO with a valid/ready handshake toward the downstream consumer.

Parameters:
- KEEP_EVERY, 2, keep one sample in every KEEP_EVERY accepted samples (the last of each group); range 1..16.
- RELU, 0, 1 clamps negative results to 0 before output.
- DEPTH, 4, output FIFO depth in entries; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  16  IEEE half-precision accumulator value.
- out_valid  out  1  out_data holds a valid FIFO head.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  8  signed int8 result (two's complement).
- sat_count  out  16  saturating count of results clamped to ±limit, including Inf.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, sat_count=0, FIFO empty, pipeline empty, phase counter=0. in_ready=1 from the cycle after reset is released. Reset mid-operation discards all in-flight and buffered data.
- Accept: a sample is accepted when in_valid && in_ready at a clk edge.
- Phase counter: 0..KEEP_EVERY-1, increments per accepted sample and wraps. The sample accepted at phase KEEP_EVERY-1 is kept; all others are dropped with no other effect. With KEEP_EVERY=1, every sample is kept.
- in_ready = (fifo_count + inflight_kept) < DEPTH, where inflight_kept counts kept samples in the 2 pipeline stages. Dropped samples are also gated by in_ready.
- Stage 1 (edge N+1 after acceptance at edge N): register sign s, exponent e, mantissa m with the hidden bit, and a class code zero/subnormal, normal, inf, nan.
- Stage 2 (edge N+2), using unbiased E = e-15:
  - zero, subnormal, or E < -1: 0.
  - E = -1: magnitude 1 (0.5 ≤ |v| < 1 rounds half away from zero).
  - 0 ≤ E ≤ 6: mag = {1,m} >> (10-E), rounded half away from zero using the guard bit.
  - E ≥ 7 or inf: saturate.
  - nan: 0, and sat_count is not incremented.
- Saturation limits: positive to 127; negative magnitude > 128 to -128. Exactly -128.0 gives 0x80 and does not count as saturation. Every other saturation event increments sat_count, which sticks at 0xFFFF.
- ReLU: when RELU=1, a negative result becomes 0 (applied after rounding) and does not count toward sat_count.
- FIFO write: the stage-2 result is written to the FIFO at edge N+2. With an empty FIFO, out_valid=1 in the cycle after edge N+2, so latency is 2 edges.
- FIFO output: out_data is the registered FIFO head. It holds stable while out_valid && !out_ready. A pop occurs when out_valid && out_ready.
- Simultaneous push and pop when full is legal. Credit gating guarantees no overflow, so no data is ever lost.
- out_data keeps its last popped value when out_valid=0.

Decomposition:
- Shared package fp16_pkg:
  - FP16 field widths (sign 1, exp 5, mant 10) and EXP_BIAS=15.
  - Class enum FP_ZERO/FP_NORM/FP_INF/FP_NAN.
  - INT8_MAX=127, INT8_MIN=-128.
- One sub-module: sync_fifo (parameterised width and depth, registered head, count output). It can be reused by other stream stages.

Test Plan:
- KEEP_EVERY=1, RELU=0: 0x5640 (100.0) -> 0x64; 0xD640 (-100.0) -> 0x9C; 0x4100 (2.5) -> 0x03; 0xC100 (-2.5) -> 0xFD; 0x3800 (0.5) -> 0x01. Each appears 2 edges after acceptance.
- Saturation: 0x5A00 (192) -> 0x7F; 0xFC00 (-Inf) -> 0x80; 0xD800 (-128) -> 0x80; 0x7E00 (NaN) -> 0x00. sat_count ends at 2.
- RELU=1: 0xD640 -> 0x00 with sat_count unchanged; 0x5640 -> 0x64.
- KEEP_EVERY=2: input 1.0, 2.0, 3.0, 4.0 back-to-back -> outputs exactly 0x02, 0x04. Assert rst after the third sample; the next accepted sample is phase 0 and is dropped.
- Backpressure, DEPTH=4: hold out_ready=0 and stream in_valid=1. in_ready drops after 4 kept samples, including in-flight ones. Release out_ready: 4 outputs pop in order with no loss or duplication, and in_ready reasserts.
- Reset mid-stream with FIFO holding 3 entries -> out_valid=0 and sat_count=0 the next cycle; no stale data is emitted afterwards.
